// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default operand width and the command record
// exchanged between the command queue and the ALU stage.
package alu_pkg;

  localparam int OPW_DEF = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef struct packed {
    logic [OPW_DEF-1:0] a;
    logic [OPW_DEF-1:0] b;
    logic [1:0]         sel;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_mem.sv
// Command storage: DEPTH x alu_cmd_t, one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module alu_cmd_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  alu_cmd_t                 wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output alu_cmd_t                 rdata_o
);

  alu_cmd_t mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_cmd_queue.sv
// In-order command queue in front of the ALU: valid/ready on both sides,
// no bypass or pass-through, and divide-by-zero flagging of the head command.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW   = OPW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW-1:0]         in_a,
  input  logic [OPW-1:0]         in_b,
  input  logic [1:0]             in_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPW-1:0]         out_a,
  output logic [OPW-1:0]         out_b,
  output logic [1:0]             out_sel,
  output logic                   out_dz,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dz_seen
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dz_seen_q, dz_seen_d;
  logic          push_s, pop_s, dz_s;
  alu_cmd_t      wcmd_s, head_s;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != {CW{1'b0}});
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  assign wcmd_s = '{a: in_a, b: in_b, sel: in_sel};

  alu_cmd_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wcmd_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_s)
  );

  // Head outputs are forced to zero while empty so stale storage never leaks
  assign out_a   = out_valid ? head_s.a   : {OPW{1'b0}};
  assign out_b   = out_valid ? head_s.b   : {OPW{1'b0}};
  assign out_sel = out_valid ? head_s.sel : 2'b00;
  assign dz_s    = out_valid && (head_s.sel == OP_DIV) && (head_s.b == {OPW{1'b0}});
  assign out_dz  = dz_s;
  assign count   = count_q;
  assign dz_seen = dz_seen_q;

  // Next-state for pointers, occupancy and the sticky divide-by-zero flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dz_seen_d = dz_seen_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop_s && dz_s) begin
      dz_seen_d = 1'b1;
    end else begin
      dz_seen_d = dz_seen_q;
    end
  end

  // State registers with synchronous active-low reset taking priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      dz_seen_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dz_seen_q <= dz_seen_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue: a queue-based reference model tracks
// accepted commands; a negedge monitor compares every visible output.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int OPW   = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready;
  logic [OPW-1:0] in_a, in_b;
  logic [1:0]     in_sel;
  logic           out_valid, out_ready;
  logic [OPW-1:0] out_a, out_b;
  logic [1:0]     out_sel;
  logic           out_dz;
  logic [2:0]     count;
  logic           dz_seen;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_cmd_t exp_q[$];
  bit       model_dz = 1'b0;
  bit       chk_en   = 1'b0;

  alu_cmd_queue #(.DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_sel   (out_sel),
    .out_dz    (out_dz),
    .count     (count),
    .dz_seen   (dz_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ordered list of accepted commands, capacity DEPTH
  always @(posedge clk) begin
    alu_cmd_t h;
    bit do_push, do_pop;
    if (!rst_n) begin
      exp_q.delete();
      model_dz = 1'b0;
      chk_en   = 1'b1;
    end else begin
      do_pop  = out_ready && (exp_q.size() > 0);
      do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop) begin
        h = exp_q.pop_front();
        if (h.sel == OP_DIV && h.b == 4'd0) model_dz = 1'b1;
      end
      if (do_push) exp_q.push_back('{a: in_a, b: in_b, sel: in_sel});
    end
  end

  // Monitor: compare handshake state and the head against the model
  always @(negedge clk) begin
    alu_cmd_t h;
    if (chk_en) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("dz_seen", 32'(dz_seen), 32'(model_dz));
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        chk("out_a", 32'(out_a), 32'(h.a));
        chk("out_b", 32'(out_b), 32'(h.b));
        chk("out_sel", 32'(out_sel), 32'(h.sel));
        chk("out_dz", 32'(out_dz), 32'(h.sel == 2'b11 && h.b == 4'd0));
      end else begin
        chk("idle_out", 32'({out_a, out_b, out_sel, out_dz}), 32'd0);
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] s, input logic r);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sel    = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);

    // single command, held then consumed
    step(1'b1, 4'd3, 4'd5, 2'b00, 1'b0);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);

    // fill, refused fifth push, drain
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 4'(i + 8), 2'b01, 1'b0);
    step(1'b1, 4'd9, 4'd9, 2'b10, 1'b0);
    step(1'b1, 4'd9, 4'd9, 2'b10, 1'b1);
    repeat (5) step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);

    // streaming with pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 4'(15 - i), 2'(i), 1'b1);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);

    // divide by zero then a legal divide
    step(1'b1, 4'd7, 4'd0, 2'b11, 1'b0);
    step(1'b1, 4'd7, 4'd2, 2'b11, 1'b0);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    repeat (2) step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);

    // reset with three entries queued while pushing and popping
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 4), 4'd0, 2'b11, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 4'd1, 4'd1, 2'b00, 1'b1);
    rst_n = 1'b1;
    step(1'b1, 4'd6, 4'd3, 2'b10, 1'b0);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);

    // randomized traffic with rare resets
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
    end
    rst_n = 1'b1;
    repeat (6) step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
